gand: RTL and testbench

//   Bitwise 2-input AND gate (trabalho01 gate library) with a combinational output.

---
 rtl/gand.sv | 44 ++++
 tb/tb_gand.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gand.sv
// rtl/gand.sv - bitwise AND gate with registered output and saturating high-cycle counter
module gand #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     y,
  output logic [WIDTH-1:0]     y_q,
  output logic [CNT_WIDTH-1:0] hi_cnt,
  output logic                 hi_sat
);

  logic [WIDTH-1:0]     y_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign y   = a & b;
  assign y_d = y;

  // Counter freezes at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if ((&y) && !hi_sat) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  assign hi_cnt = cnt_q;
  assign hi_sat = (cnt_q == {CNT_WIDTH{1'b1}});

endmodule

// File: tb/tb_gand.sv
// tb/tb_gand.sv - randomized and directed checks of gand against a behavioural model
module tb_gand;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [3:0] a3 = 4'h0, b3 = 4'h0;

  logic        y1, yq1, y2, yq2, sat1, sat2, sat3;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;
  logic [3:0]  y3, yq3;
  logic [2:0]  cnt3;

  int pass_cnt = 0;
  int total_cnt = 0;

  gand #(.WIDTH(1), .CNT_WIDTH(16)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .y(y1), .y_q(yq1), .hi_cnt(cnt1), .hi_sat(sat1)
  );
  gand #(.WIDTH(1), .CNT_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .y(y2), .y_q(yq2), .hi_cnt(cnt2), .hi_sat(sat2)
  );
  gand #(.WIDTH(4), .CNT_WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .a(a3), .b(b3),
    .y(y3), .y_q(yq3), .hi_cnt(cnt3), .hi_sat(sat3)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: counts as plain integers clamped to 2^N-1; valid only after a reset edge.
  bit m_valid = 0;
  int m_yq1, m_yq3, m_c1, m_c2, m_c3;

  function automatic int and_bits(input int x, input int y, input int w);
    int r = 0;
    for (int i = 0; i < w; i++)
      if (((x >> i) & 1) == 1 && ((y >> i) & 1) == 1) r += (1 << i);
    return r;
  endfunction

  always @(posedge clk) begin
    int p1, p3;
    p1 = and_bits(int'(a1), int'(b1), 1);
    p3 = and_bits(int'(a3), int'(b3), 4);
    if (rst) begin
      m_valid = 1;
      m_yq1 = 0; m_yq3 = 0; m_c1 = 0; m_c2 = 0; m_c3 = 0;
    end else if (m_valid) begin
      m_yq1 = p1;
      m_yq3 = p3;
      if (p1 == 1) begin
        if (m_c1 < 65535) m_c1++;
        if (m_c2 < 3) m_c2++;
      end
      if (p3 == 15 && m_c3 < 7) m_c3++;
    end
  end

  always @(negedge clk) begin
    check("y1", 32'(y1), 32'(and_bits(int'(a1), int'(b1), 1)));
    check("y2", 32'(y2), 32'(and_bits(int'(a1), int'(b1), 1)));
    check("y3", 32'(y3), 32'(and_bits(int'(a3), int'(b3), 4)));
    if (m_valid) begin
      check("yq1", 32'(yq1), 32'(m_yq1));
      check("yq2", 32'(yq2), 32'(m_yq1));
      check("yq3", 32'(yq3), 32'(m_yq3));
      check("cnt1", 32'(cnt1), 32'(m_c1));
      check("cnt2", 32'(cnt2), 32'(m_c2));
      check("cnt3", 32'(cnt3), 32'(m_c3));
      check("sat1", 32'(sat1), 32'(m_c1 == 65535));
      check("sat2", 32'(sat2), 32'(m_c2 == 3));
      check("sat3", 32'(sat3), 32'(m_c3 == 7));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_y[4];
    int exp_c[6];
    int exp_s[6];
    exp_y = '{0, 0, 0, 1};
    exp_c = '{1, 2, 3, 3, 3, 3};
    exp_s = '{0, 0, 1, 1, 1, 1};

    // Combinational sweep with the clock held static
    for (int i = 0; i < 4; i++) begin
      a1 = (i >= 2);
      b1 = (i % 2 == 1);
      #1;
      check("comb_y", 32'(y1), 32'(exp_y[i]));
      #9;
    end

    clk_en = 1'b1;
    a1 = 0; b1 = 0;
    rst = 1;
    tick();
    check("rst_yq", 32'(yq1), 32'd0);
    check("rst_cnt", 32'(cnt1), 32'd0);
    tick();
    check("rst_yq2", 32'(yq1), 32'd0);
    check("rst_cnt2", 32'(cnt1), 32'd0);
    rst = 0; a1 = 1; b1 = 1;
    tick();
    check("reg_yq_hi", 32'(yq1), 32'd1);
    a1 = 0;
    tick();
    check("reg_yq_lo", 32'(yq1), 32'd0);

    rst = 1; tick(); rst = 0;
    a1 = 1; b1 = 1;
    repeat (5) tick();
    a1 = 0;
    repeat (3) tick();
    check("cnt_5", 32'(cnt1), 32'd5);
    repeat (2) tick();
    check("cnt_hold", 32'(cnt1), 32'd5);

    rst = 1; tick(); rst = 0;
    a1 = 1; b1 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("sat_cnt", 32'(cnt2), 32'(exp_c[i]));
      check("sat_flag", 32'(sat2), 32'(exp_s[i]));
    end

    rst = 1;
    tick();
    check("prio_yq", 32'(yq2), 32'd0);
    check("prio_cnt", 32'(cnt2), 32'd0);
    check("prio_sat", 32'(sat2), 32'd0);
    check("prio_y", 32'(y2), 32'd1);
    rst = 0; a1 = 0; b1 = 0;

    a3 = 4'b1100; b3 = 4'b1010;
    #1;
    check("bitwise_y", 32'(y3), 32'h8);
    tick();
    check("bitwise_nocnt", 32'(cnt3), 32'd0);
    a3 = 4'hF; b3 = 4'hF;
    tick();
    check("bitwise_cnt", 32'(cnt3), 32'd1);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 29) == 0);
      a1 = 1'($urandom_range(0, 1));
      b1 = ($urandom_range(0, 3) != 0);
      a3 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      b3 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
